jt93cxx: RTL

- Parametrised Microwire serial EEPROM model, compatible with the 93C46/56/66/86 family in x8 and x16 organisation.
- Next generation of the team's 9346 model, adding:
  - EWEN-gated WRITE/ERASE/WRAL.
  - Sequential read with address auto-increment.
  - Programmable busy time.
  - Host dump/load port with dirty flag for NVRAM save.
- Sits between a CPU's bit-banged I/O latch and the framework's NVRAM save logic.

---
 rtl/jt93cxx_pkg.sv | 24 ++
 rtl/jt93cxx_if.sv | 11 +
 rtl/jt93cxx_ram.sv | 31 +++
 rtl/jt93cxx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/jt93cxx_pkg.sv
// jt93cxx_pkg: Microwire opcodes, extended sub-ops and one-hot FSM states for the 93Cxx EEPROM model.
package jt93cxx_pkg;
   localparam logic [1:0] OP_EXT   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_ERASE = 2'b11;
   localparam logic [1:0] EWDS = 2'b00;
   localparam logic [1:0] WRAL = 2'b01;
   localparam logic [1:0] ERAL = 2'b10;
   localparam logic [1:0] EWEN = 2'b11;
   typedef enum logic [7:0] {
      IDLE = 8'h01,
      CMD  = 8'h02,
      READ = 8'h04,
      DATA = 8'h08,
      PROG = 8'h10,
      ALL  = 8'h20,
      BUSY = 8'h40,
      WAIT = 8'h80
   } state_t;
   function automatic int max2(int a, int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/jt93cxx_if.sv
// jt93cxx_if: serial Microwire pins plus the host dump/load port of the 93Cxx model.
interface jt93cxx_if #(parameter int AW = 6, parameter int DW = 16);
   logic          sclk, sdi, scs, sdo;
   logic [AW-1:0] dump_addr;
   logic [DW-1:0] dump_din, dump_dout;
   logic          dump_we, dump_clr, dirty;
   modport master(output sclk, sdi, scs, dump_addr, dump_din, dump_we, dump_clr,
                  input sdo, dump_dout, dirty);
   modport slave(input sclk, sdi, scs, dump_addr, dump_din, dump_we, dump_clr,
                 output sdo, dump_dout, dirty);
endinterface

// File: rtl/jt93cxx_ram.sv
// jt93cxx_ram: true dual-port RAM, read-before-write, port A wins a same-address write collision when i_pri_a.
module jt93cxx_ram #(parameter int AW = 6, parameter int DW = 16) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] i_addr_a,
   input  logic [DW-1:0] i_din_a,
   input  logic          i_we_a,
   output logic [DW-1:0] o_q_a,
   input  logic [AW-1:0] i_addr_b,
   input  logic [DW-1:0] i_din_b,
   input  logic          i_we_b,
   output logic [DW-1:0] o_q_b,
   input  logic          i_pri_a
);
   logic [DW-1:0] r_mem [2**AW];
   logic          w_hit;
   assign w_hit = i_we_a & i_we_b & (i_addr_a == i_addr_b);
   always_ff @(posedge clk) begin
      if (i_we_b && !(w_hit && i_pri_a)) r_mem[i_addr_b] <= i_din_b;
      if (i_we_a && !(w_hit && !i_pri_a)) r_mem[i_addr_a] <= i_din_a;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_q_a <= '0;
         o_q_b <= '0;
      end else begin
         o_q_a <= r_mem[i_addr_a];
         o_q_b <= r_mem[i_addr_b];
      end
   end
endmodule

// File: rtl/jt93cxx.sv
// jt93cxx: 93C46/56/66/86 Microwire EEPROM model with EWEN gating, sequential read,
// programmable busy time and a host dump port with dirty flag.
module jt93cxx import jt93cxx_pkg::*; #(
   parameter int AW       = 6,
   parameter int DW       = 16,
   parameter int BUSY_CYC = 64
) (
   input logic        clk,
   input logic        rst,
   jt93cxx_if.slave   bus
);
   localparam int SW = max2(AW + 2, DW);
   localparam int CW = $clog2(SW + 1);
   localparam int BW = $clog2(BUSY_CYC + 1);

   state_t        r_state, w_state;
   logic          r_sclk, r_ewen, w_ewen, r_sdo, w_sdo, r_all, w_all, r_dirty, w_we, w_rise, w_last;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [SW-1:0] r_sr, w_sr;
   logic [AW-1:0] r_addr, w_addr;
   logic [DW-1:0] r_data, w_data, w_qa, w_qb, w_rd;
   logic [BW-1:0] r_busy, w_busy;
   logic [AW+1:0] w_cmd;

   always_comb begin
      w_rise  = bus.sclk & ~r_sclk & bus.scs;
      w_sr    = w_rise ? {r_sr[SW-2:0], bus.sdi} : r_sr;
      w_cmd   = w_sr[AW+1:0];
      w_last  = w_rise && r_cnt == CW'(1);
      w_rd    = w_qa >> r_cnt;
      w_state = r_state;
      w_cnt   = r_cnt;
      w_addr  = r_addr;
      w_data  = r_data;
      w_ewen  = r_ewen;
      w_sdo   = r_sdo;
      w_all   = r_all;
      w_busy  = r_busy;
      w_we    = 1'b0;
      case (r_state)
         IDLE: if (w_rise && bus.sdi) begin
            w_state = CMD;
            w_cnt   = CW'(AW + 2);
         end
         CMD: if (w_rise) begin
            w_cnt = r_cnt - 1'b1;
            if (w_last) begin
               w_addr  = w_cmd[AW-1:0];
               w_data  = '1;
               w_state = WAIT;
               case (w_cmd[AW+1:AW])
                  OP_READ: begin
                     w_state = READ;
                     w_cnt   = CW'(DW - 1);
                     w_sdo   = 1'b0;
                  end
                  OP_WRITE: if (r_ewen) begin
                     w_state = DATA;
                     w_cnt   = CW'(DW);
                     w_all   = 1'b0;
                  end
                  OP_ERASE: if (r_ewen) w_state = PROG;
                  default: case (w_cmd[AW-1:AW-2])
                     EWEN: w_ewen = 1'b1;
                     EWDS: w_ewen = 1'b0;
                     ERAL: if (r_ewen) begin
                        w_state = ALL;
                        w_addr  = '0;
                     end
                     default: if (r_ewen) begin
                        w_state = DATA;
                        w_cnt   = CW'(DW);
                        w_all   = 1'b1;
                     end
                  endcase
               endcase
            end
         end
         // Bit 0 of a word bumps the address so the next word is already fetched by the next edge
         READ: if (w_rise) begin
            w_sdo = w_rd[0];
            w_cnt = r_cnt == '0 ? CW'(DW - 1) : r_cnt - 1'b1;
            w_addr = r_cnt == '0 ? r_addr + 1'b1 : r_addr;
         end
         DATA: if (w_rise) begin
            w_cnt = r_cnt - 1'b1;
            if (w_last) begin
               w_data  = w_sr[DW-1:0];
               w_state = r_all ? ALL : PROG;
               w_addr  = r_all ? '0 : r_addr;
            end
         end
         PROG: begin
            w_we    = 1'b1;
            w_state = BUSY;
            w_busy  = BW'(BUSY_CYC);
         end
         ALL: begin
            w_we    = 1'b1;
            w_addr  = r_addr + 1'b1;
            w_state = &r_addr ? BUSY : ALL;
            w_busy  = BW'(BUSY_CYC);
         end
         BUSY: begin
            w_busy  = r_busy - 1'b1;
            w_state = r_busy == BW'(1) ? WAIT : BUSY;
         end
         default: ;
      endcase
      if (!bus.scs && !(r_state inside {PROG, ALL, BUSY})) w_state = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_sclk  <= 1'b0;
         r_cnt   <= '0;
         r_sr    <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_ewen  <= 1'b0;
         r_sdo   <= 1'b1;
         r_all   <= 1'b0;
         r_busy  <= '0;
         r_dirty <= 1'b0;
      end else begin
         r_state <= w_state;
         r_sclk  <= bus.sclk;
         r_cnt   <= w_cnt;
         r_sr    <= w_sr;
         r_addr  <= w_addr;
         r_data  <= w_data;
         r_ewen  <= w_ewen;
         r_sdo   <= w_sdo;
         r_all   <= w_all;
         r_busy  <= w_busy;
         r_dirty <= w_we | (r_dirty & ~bus.dump_clr);
      end
   end

   jt93cxx_ram #(.AW(AW), .DW(DW)) u_ram (
      .clk      (clk),
      .rst      (rst),
      .i_addr_a (r_addr),
      .i_din_a  (r_data),
      .i_we_a   (w_we),
      .o_q_a    (w_qa),
      .i_addr_b (bus.dump_addr),
      .i_din_b  (bus.dump_din),
      .i_we_b   (bus.dump_we),
      .o_q_b    (w_qb),
      .i_pri_a  (1'b1)
   );

   assign bus.dump_dout = w_qb;
   assign bus.dirty     = r_dirty;
   assign bus.sdo       = (r_state == READ) ? r_sdo : (r_state != BUSY);
endmodule
